hack_alu_pipe: RTL and testbench
================================

Name: hack_alu_pipe

Overview:
Parametrised, pipelined successor to the combinational Hack ALU. It applies the same six-bit control encoding (zx, nx, zy, ny, f, no) to WIDTH-bit operands. Operations pass through a 2-stage register pipeline with valid/ready handshakes on both sides. It adds carry and signed-overflow flags, and sits between the CPU decode stage and the writeback/flag register.

Parameters:
WIDTH, 16, operand and result width in bits (must be ≥ 2)

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream presents an operation this cycle
in_ready  output  1  block accepts the operation this cycle
x  input  WIDTH  operand x
y  input  WIDTH  operand y
ctrl  input  6  {zx,nx,zy,ny,f,no}, bit 5 = zx, bit 0 = no
out_valid  output  1  result and flags valid
out_ready  input  1  downstream accepts the result this cycle
out  output  WIDTH  result
zr  output  1  out == 0
ng  output  1  out[WIDTH-1]
cy  output  1  carry out of the add (0 when f = 0)
ov  output  1  signed overflow of the add (0 when f = 0)

Behaviour:
- Transfers: input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Stage 1 (S1) captures on input transfer:
  - px = zx ? 0 : x, then px = nx ? ~px : px.
  - py = zy ? 0 : y, then py = ny ? ~py : py.
  - Also captures f and no, and sets s1_valid.
- Stage 2 (S2) captures from S1 when S1 advances:
  - sum = px + py, computed in WIDTH+1 bits. cy = sum[WIDTH]. ov = (px[MSB] == py[MSB]) & (sum[MSB] != px[MSB]).
  - r = f ? sum[WIDTH-1:0] : (px & py). When f = 0, cy = ov = 0.
  - out = no ? ~r : r. This is bitwise NOT (Hack semantics), not two's-complement negate.
  - zr and ng are derived from the final out. cy and ov are taken from the pre-negation add.
- Advance rules:
  - s2_adv = s1_valid & (~s2_valid | out_ready).
  - in_ready = ~s1_valid | s2_adv (combinational; depends on out_ready, no dependence on in_valid).
- Same-cycle pass-through: if S1 advances and a new input transfers in the same cycle, S1 reloads and s1_valid stays 1.
- S2 drains: if S2 is drained (output transfer) with no S1 advance, s2_valid clears.
- Latency: result appears exactly 2 cycles after the input transfer when unstalled. Throughput is 1 op/cycle with out_ready held high.
- Back-pressure:
  - out_ready = 0 holds out and all flags stable while out_valid = 1.
  - With S2 full and stalled, S1 holds one further op; in_ready drops to 0 only when both stages are full.
  - No op is dropped or duplicated.
- Output-register invariance: out, zr, ng, cy, ov are registers in S2 and change only on an S2 load.
- Reset (asynchronous, any time, including mid-stream):
  - s1_valid = s2_valid = 0, out_valid = 0.
  - out = 0, zr = 1, ng = 0, cy = 0, ov = 0.
  - S1 data registers are cleared to 0.
  - in_ready = 1 from the first cycle after reset deasserts.
  - In-flight ops are discarded.
- Width rules: all arithmetic wraps modulo 2^WIDTH. MSB means bit WIDTH-1.
- Don't-care inputs: ctrl, x and y are ignored when in_valid = 0. out is don't-care-free (held) when out_valid = 0.

Test Plan:
- Add, WIDTH=16, ctrl=000010, x=7FFF, y=0001, out_ready=1 -> 2 cycles later out=8000, ng=1, zr=0, cy=0, ov=1, out_valid for 1 cycle.
- Add wrap, ctrl=000010, x=FFFF, y=0001 -> out=0000, zr=1, cy=1, ov=0. Then constant -1, ctrl=111010 -> out=FFFF, ng=1, cy=0, ov=0.
- x-y, ctrl=010011, x=0005, y=0003 -> out=0002. !x, ctrl=001101, x=00F0 -> out=FF0F, cy=ov=0. Zero, ctrl=101010 -> out=0000, zr=1.
- Back-pressure: stream 4 ops back-to-back with out_ready=0 -> in_ready=0 after 2 accepts, out/flags frozen. Raise out_ready -> 4 results emerge in order, one per cycle, none lost.
- Reset mid-stream: assert reset with both stages valid -> out_valid=0, out=0, zr=1, ng=cy=ov=0 immediately. After release, the first new op returns its correct result 2 cycles after acceptance.
- Parameter sweep, WIDTH=8: ctrl=000010, x=80, y=80 -> out=00, zr=1, cy=1, ov=1. WIDTH=32 add 7FFFFFFF+1 -> out=80000000, ov=1.

Source files
------------

// File: rtl/hack_alu_pipe.sv
// hack_alu_pipe: two-stage pipelined Hack ALU with valid/ready handshakes on
// both sides. S1 holds the conditioned operands (zx/nx, zy/ny already applied)
// plus f/no; S2 holds the registered result together with zr, ng, cy and ov.
module hack_alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov
);

  localparam int MSB = WIDTH - 1;

  // Operand conditioning: optional force-to-zero, then optional bitwise invert.
  function automatic logic [WIDTH-1:0] precondition(input logic [WIDTH-1:0] v,
                                                    input logic             zero,
                                                    input logic             inv);
    logic [WIDTH-1:0] t;
    t = zero ? {WIDTH{1'b0}} : v;
    precondition = inv ? ~t : t;
  endfunction

  // Signed overflow of px + py: operands agree in sign, result sign differs.
  function automatic logic add_overflow(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
    add_overflow = (a_msb == b_msb) & (s_msb != a_msb);
  endfunction

  // Stage 1 state
  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_px_r;
  logic [WIDTH-1:0] s1_py_r;
  logic             s1_f_r;
  logic             s1_no_r;

  // Stage 2 state (drives the outputs directly)
  logic             s2_valid_r;
  logic [WIDTH-1:0] s2_out_r;
  logic             s2_zr_r;
  logic             s2_ng_r;
  logic             s2_cy_r;
  logic             s2_ov_r;

  // Handshake and datapath nets
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             s2_adv_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] r_s;
  logic             cy_s;
  logic             ov_s;
  logic [WIDTH-1:0] out_nx_s;

  // S1 moves into S2 whenever S2 is empty or is being drained this cycle.
  assign s2_adv_s   = s1_valid_r & (~s2_valid_r | out_ready);
  assign in_ready   = ~s1_valid_r | s2_adv_s;
  assign in_xfer_s  = in_valid & in_ready;
  assign out_xfer_s = s2_valid_r & out_ready;

  assign out_valid = s2_valid_r;
  assign out       = s2_out_r;
  assign zr        = s2_zr_r;
  assign ng        = s2_ng_r;
  assign cy        = s2_cy_r;
  assign ov        = s2_ov_r;

  // S1 capture: load on input transfer (also covers same-cycle pass-through),
  // otherwise empty the stage when its op moves on to S2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_px_r    <= {WIDTH{1'b0}};
      s1_py_r    <= {WIDTH{1'b0}};
      s1_f_r     <= 1'b0;
      s1_no_r    <= 1'b0;
    end else if (in_xfer_s) begin
      s1_valid_r <= 1'b1;
      s1_px_r    <= precondition(x, ctrl[5], ctrl[4]);
      s1_py_r    <= precondition(y, ctrl[3], ctrl[2]);
      s1_f_r     <= ctrl[1];
      s1_no_r    <= ctrl[0];
    end else if (s2_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // S2 next value: add or AND, flags from the pre-negation add, then optional NOT.
  always_comb begin
    sum_s    = {1'b0, s1_px_r} + {1'b0, s1_py_r};
    r_s      = {WIDTH{1'b0}};
    cy_s     = 1'b0;
    ov_s     = 1'b0;
    if (s1_f_r) begin
      r_s  = sum_s[WIDTH-1:0];
      cy_s = sum_s[WIDTH];
      ov_s = add_overflow(s1_px_r[MSB], s1_py_r[MSB], sum_s[MSB]);
    end else begin
      r_s  = s1_px_r & s1_py_r;
      cy_s = 1'b0;
      ov_s = 1'b0;
    end
    out_nx_s = s1_no_r ? ~r_s : r_s;
  end

  // S2 capture: result and flags change only on a load; a drain with no
  // incoming op just clears the valid bit so the data stays held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      s2_out_r   <= {WIDTH{1'b0}};
      s2_zr_r    <= 1'b1;
      s2_ng_r    <= 1'b0;
      s2_cy_r    <= 1'b0;
      s2_ov_r    <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= 1'b1;
      s2_out_r   <= out_nx_s;
      s2_zr_r    <= (out_nx_s == {WIDTH{1'b0}});
      s2_ng_r    <= out_nx_s[MSB];
      s2_cy_r    <= cy_s;
      s2_ov_r    <= ov_s;
    end else if (out_xfer_s) begin
      s2_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Testbench for hack_alu_pipe: WIDTH=16 instance checked through a scoreboard,
// plus WIDTH=8 and WIDTH=32 instances for the parameter sweep.
module tb_hack_alu_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // WIDTH = 16
  logic        d16_in_valid, d16_in_ready, d16_out_valid, d16_out_ready;
  logic [15:0] d16_x, d16_y, d16_out;
  logic [5:0]  d16_ctrl;
  logic        d16_zr, d16_ng, d16_cy, d16_ov;

  // WIDTH = 8
  logic        d8_in_valid, d8_in_ready, d8_out_valid, d8_out_ready;
  logic [7:0]  d8_x, d8_y, d8_out;
  logic [5:0]  d8_ctrl;
  logic        d8_zr, d8_ng, d8_cy, d8_ov;

  // WIDTH = 32
  logic        d32_in_valid, d32_in_ready, d32_out_valid, d32_out_ready;
  logic [31:0] d32_x, d32_y, d32_out;
  logic [5:0]  d32_ctrl;
  logic        d32_zr, d32_ng, d32_cy, d32_ov;

  hack_alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(d16_in_valid), .in_ready(d16_in_ready),
    .x(d16_x), .y(d16_y), .ctrl(d16_ctrl), .out_valid(d16_out_valid),
    .out_ready(d16_out_ready), .out(d16_out), .zr(d16_zr), .ng(d16_ng),
    .cy(d16_cy), .ov(d16_ov));

  hack_alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
    .x(d8_x), .y(d8_y), .ctrl(d8_ctrl), .out_valid(d8_out_valid),
    .out_ready(d8_out_ready), .out(d8_out), .zr(d8_zr), .ng(d8_ng),
    .cy(d8_cy), .ov(d8_ov));

  hack_alu_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(d32_in_valid), .in_ready(d32_in_ready),
    .x(d32_x), .y(d32_y), .ctrl(d32_ctrl), .out_valid(d32_out_valid),
    .out_ready(d32_out_ready), .out(d32_out), .zr(d32_zr), .ng(d32_ng),
    .cy(d32_cy), .ov(d32_ov));

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [19:0] sb[$];   // {out, zr, ng, cy, ov}

  // Reference ALU for WIDTH=16; overflow taken from integer range, not sign bits.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [5:0] c);
    logic [15:0] p, q, r;
    logic [16:0] s;
    logic        cv, vv;
    int          si;
    p = c[5] ? 16'h0000 : a;
    if (c[4]) p = ~p;
    q = c[3] ? 16'h0000 : b;
    if (c[2]) q = ~q;
    s  = {1'b0, p} + {1'b0, q};
    si = int'($signed(p)) + int'($signed(q));
    if (c[1]) begin
      r  = s[15:0];
      cv = s[16];
      vv = (si > 32767) || (si < -32768);
    end else begin
      r  = p & q;
      cv = 1'b0;
      vv = 1'b0;
    end
    if (c[0]) r = ~r;
    return {r, (r == 16'h0000), r[15], cv, vv};
  endfunction

  // Output monitor: pops the scoreboard on every output transfer.
  task automatic monitor_loop();
    logic [19:0] exp_v, got_v;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && d16_out_valid && d16_out_ready) begin
        checks++;
        pops++;
        got_v = {d16_out, d16_zr, d16_ng, d16_cy, d16_ov};
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_output got=%h (queue empty)", got_v);
        end else begin
          exp_v = sb.pop_front();
          if (got_v !== exp_v) begin
            errors++;
            $display("FAIL sb_result got=%h expected=%h", got_v, exp_v);
          end
        end
      end
    end
  endtask

  // Present one op and wait (bounded) until it is accepted; push its result.
  task automatic send(input logic [15:0] xv, input logic [15:0] yv,
                      input logic [5:0] c, input logic [19:0] expv);
    int n;
    n = 0;
    @(negedge clk);
    d16_in_valid = 1'b1;
    d16_x = xv;
    d16_y = yv;
    d16_ctrl = c;
    #1;
    while (!d16_in_ready && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!d16_in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%b expected=1", d16_in_ready);
    end else begin
      sb.push_back(expv);
    end
  endtask

  task automatic sendm(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] c);
    send(xv, yv, c, model(xv, yv, c));
  endtask

  task automatic idle();
    @(negedge clk);
    d16_in_valid = 1'b0;
  endtask

  // Wait (bounded) for the scoreboard to empty, then check nothing is left.
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || d16_out_valid) && n < 40) begin
      @(negedge clk);
      #3;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d expected=0", name, sb.size());
    end
  endtask

  // Called right after send() of an op into an empty pipe: valid exactly in cycle +2.
  task automatic check_latency(input string name);
    @(posedge clk);
    #1;
    d16_in_valid = 1'b0;
    checks++;
    if (d16_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_lat1 out_valid=%b expected=0", name, d16_out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (d16_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_lat2 out_valid=%b expected=1", name, d16_out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (d16_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_lat3 out_valid=%b expected=0", name, d16_out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    d16_in_valid = 1'b0; d16_out_ready = 1'b1;
    d16_x = 16'h0; d16_y = 16'h0; d16_ctrl = 6'b0;
    d8_in_valid = 1'b0; d8_out_ready = 1'b1; d8_x = 8'h0; d8_y = 8'h0; d8_ctrl = 6'b0;
    d32_in_valid = 1'b0; d32_out_ready = 1'b1; d32_x = 32'h0; d32_y = 32'h0; d32_ctrl = 6'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({d16_out_valid, d16_out, d16_zr, d16_ng, d16_cy, d16_ov} !== {1'b0, 16'h0000, 4'b1000}) begin
      errors++;
      $display("FAIL reset_state got=%b_%h_%b%b%b%b expected=0_0000_1000",
               d16_out_valid, d16_out, d16_zr, d16_ng, d16_cy, d16_ov);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (d16_in_ready !== 1'b1 || d16_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%b out_valid=%b expected 1 0",
               d16_in_ready, d16_out_valid);
    end
  endtask

  task automatic test_add();
    send(16'h7FFF, 16'h0001, 6'b000010, {16'h8000, 4'b0101});
    check_latency("add");
    send(16'hFFFF, 16'h0001, 6'b000010, {16'h0000, 4'b1010});
    check_latency("add_wrap");
    send(16'h1234, 16'h5678, 6'b111010, {16'hFFFF, 4'b0100});
    check_latency("minus_one");
    drain("add");
  endtask

  task automatic test_logic_ops();
    send(16'h0005, 16'h0003, 6'b010011, {16'h0002, 4'b0000});
    send(16'h00F0, 16'hAAAA, 6'b001101, {16'hFF0F, 4'b0100});
    send(16'h9999, 16'h7777, 6'b101010, {16'h0000, 4'b1000});
    idle();
    drain("logic_ops");
  endtask

  task automatic test_back_pressure();
    logic [19:0] held;
    int p0;
    p0 = pops;
    d16_out_ready = 1'b0;
    sendm(16'h0101, 16'h0202, 6'b000010);
    sendm(16'h8000, 16'h8000, 6'b000010);
    @(negedge clk);
    d16_x = 16'h0003; d16_y = 16'h0004; d16_ctrl = 6'b000000;
    #1;
    checks++;
    if (d16_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_in_ready got=%b expected=0", d16_in_ready);
    end
    held = {d16_out, d16_zr, d16_ng, d16_cy, d16_ov};
    checks++;
    if (d16_out_valid !== 1'b1 || held !== model(16'h0101, 16'h0202, 6'b000010)) begin
      errors++;
      $display("FAIL bp_head got=%b_%h expected=1_%h", d16_out_valid, held,
               model(16'h0101, 16'h0202, 6'b000010));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (d16_in_ready !== 1'b0 || {d16_out, d16_zr, d16_ng, d16_cy, d16_ov} !== held) begin
        errors++;
        $display("FAIL bp_hold in_ready=%b out=%h expected 0 %h", d16_in_ready,
                 {d16_out, d16_zr, d16_ng, d16_cy, d16_ov}, held);
      end
    end
    d16_in_valid = 1'b0;
    d16_out_ready = 1'b1;
    sendm(16'h0003, 16'h0004, 6'b000000);
    sendm(16'hFFFF, 16'h0000, 6'b000111);
    idle();
    drain("bp");
    checks++;
    if (pops - p0 != 4) begin
      errors++;
      $display("FAIL bp_count got=%0d expected=4", pops - p0);
    end
  endtask

  task automatic test_reset_midstream();
    d16_out_ready = 1'b0;
    sendm(16'h1111, 16'h2222, 6'b000010);
    sendm(16'h3333, 16'h4444, 6'b000010);
    idle();
    @(negedge clk);
    #3;
    checks++;
    if (d16_out_valid !== 1'b1 || d16_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_full out_valid=%b in_ready=%b expected 1 0",
               d16_out_valid, d16_in_ready);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({d16_out_valid, d16_out, d16_zr, d16_ng, d16_cy, d16_ov} !== {1'b0, 16'h0000, 4'b1000}) begin
      errors++;
      $display("FAIL midrst_state got=%b_%h_%b%b%b%b expected=0_0000_1000",
               d16_out_valid, d16_out, d16_zr, d16_ng, d16_cy, d16_ov);
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    d16_out_ready = 1'b1;
    send(16'h0005, 16'h0003, 6'b010011, {16'h0002, 4'b0000});
    check_latency("post_reset");
    drain("post_reset");
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          sendm(16'($urandom), 16'($urandom), 6'($urandom));
        idle();
        done = 1'b1;
      end
      begin
        for (int k = 0; k < 2000 && !done; k++) begin
          @(negedge clk);
          d16_out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    d16_out_ready = 1'b1;
    drain("random");
  endtask

  task automatic test_width_sweep();
    @(negedge clk);
    d8_in_valid = 1'b1; d8_x = 8'h80; d8_y = 8'h80; d8_ctrl = 6'b000010;
    d32_in_valid = 1'b1; d32_x = 32'h7FFFFFFF; d32_y = 32'h00000001; d32_ctrl = 6'b000010;
    @(posedge clk);
    #1;
    d8_in_valid = 1'b0;
    d32_in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({d8_out_valid, d8_out, d8_zr, d8_ng, d8_cy, d8_ov} !== {1'b1, 8'h00, 4'b1011}) begin
      errors++;
      $display("FAIL w8_add got=%b_%h_%b%b%b%b expected=1_00_1011",
               d8_out_valid, d8_out, d8_zr, d8_ng, d8_cy, d8_ov);
    end
    checks++;
    if ({d32_out_valid, d32_out, d32_zr, d32_ng, d32_cy, d32_ov} !== {1'b1, 32'h80000000, 4'b0101}) begin
      errors++;
      $display("FAIL w32_add got=%b_%h_%b%b%b%b expected=1_80000000_0101",
               d32_out_valid, d32_out, d32_zr, d32_ng, d32_cy, d32_ov);
    end
  endtask

  // Test sequence
  initial begin
    test_reset();
    fork
      monitor_loop();
    join_none
    test_add();
    test_logic_ops();
    test_back_pressure();
    test_reset_midstream();
    test_random();
    test_width_sweep();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
